// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter plus single-outstanding instruction fetch.
// Walks IDLE -> REQ -> VALID; the PC advances (sequential/branch/jump) only
// when the consumer accepts the current instruction with PCWre in VALID.
// Optional macro FETCH_TIMEOUT_EN adds a 4-bit stall counter that pulses
// fetchErr after 16 consecutive unanswered REQ cycles.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        PCWre,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] extendImme,
  input  logic [25:0] jumpAddr,
  input  logic        imemReady,
  input  logic [31:0] imemData,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  output logic [31:0] curPC,
  output logic [31:0] nextPC,
  output logic [31:0] instr,
  output logic        instrValid,
  output logic [15:0] imme,
  output logic        fetchErr
);

  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              w_load_instr;
  logic              w_advance_pc;
  logic [PC_W-1:0]   r_cur_pc;
  logic [PC_W-1:0]   r_instr;
  logic              r_instr_valid;
  logic              r_imem_req;
  logic [PC_W-1:0]   w_pc_plus4;
  logic [PC_W-1:0]   w_branch_pc;
  logic [PC_W-1:0]   w_jump_pc;
  logic [PC_W-1:0]   w_next_pc;

  // State register
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and datapath strobes
  always_comb begin
    w_next_state = r_state;
    w_load_instr = 1'b0;
    w_advance_pc = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_next_state = S_REQ;
      end
      S_REQ: begin
        if (imemReady) begin
          w_load_instr = 1'b1;
          w_next_state = S_VALID;
        end
      end
      S_VALID: begin
        if (PCWre) begin
          w_advance_pc = 1'b1;
          w_next_state = S_REQ;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Next-PC selection; all sums wrap modulo 2^32
  always_comb begin
    w_pc_plus4  = r_cur_pc + PC_W'(4);
    w_branch_pc = w_pc_plus4 + (extendImme << 2);
    w_jump_pc   = {w_pc_plus4[31:28], jumpAddr, 2'b00};
    w_next_pc   = w_pc_plus4;
    case (PCSrc)
      2'b01:   w_next_pc = w_branch_pc;
      2'b10:   w_next_pc = w_jump_pc;
      default: w_next_pc = w_pc_plus4;
    endcase
  end

  // PC, instruction latch and fetch request; imemReq tracks the state being entered
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_cur_pc      <= RESET_PC;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
      r_imem_req    <= 1'b0;
    end else begin
      r_imem_req <= (w_next_state == S_REQ);
      if (w_load_instr) begin
        r_instr       <= imemData;
        r_instr_valid <= 1'b1;
      end else if (w_advance_pc) begin
        r_cur_pc      <= w_next_pc;
        r_instr_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_TIMEOUT_EN
  logic [CNT_W-1:0] r_timeout_cnt;
  logic             r_fetch_err;

  // Count unanswered REQ cycles; the 16th raises a one-cycle error and restarts
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_timeout_cnt <= '0;
      r_fetch_err   <= 1'b0;
    end else begin
      r_fetch_err <= 1'b0;
      if ((r_state == S_REQ) && !imemReady) begin
        if (r_timeout_cnt == CNT_W'(15)) begin
          r_timeout_cnt <= '0;
          r_fetch_err   <= 1'b1;
        end else begin
          r_timeout_cnt <= r_timeout_cnt + CNT_W'(1);
        end
      end else begin
        r_timeout_cnt <= '0;
      end
    end
  end

  assign fetchErr = r_fetch_err;
`else
  assign fetchErr = 1'b0;
`endif

  assign imemReq    = r_imem_req;
  assign imemAddr   = r_cur_pc;
  assign curPC      = r_cur_pc;
  assign nextPC     = w_next_pc;
  assign instr      = r_instr;
  assign instrValid = r_instr_valid;
  assign imme       = r_instr[15:0];

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed testbench for pc_fetch_unit: reset, fetch handshake, next-PC
// modes, stall hold, wrap-around, fetch timeout and mid-fetch reset.
module tb_pc_fetch_unit;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        PCWre;
  logic [1:0]  PCSrc;
  logic [31:0] extendImme;
  logic [25:0] jumpAddr;
  logic        imemReady;
  logic [31:0] imemData;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] curPC;
  logic [31:0] nextPC;
  logic [31:0] instr;
  logic        instrValid;
  logic [15:0] imme;
  logic        fetchErr;

  int checks = 0;
  int errors = 0;

`ifdef FETCH_TIMEOUT_EN
  localparam int EXP_PULSES = 1;
  localparam int EXP_POS    = 16;
`else
  localparam int EXP_PULSES = 0;
  localparam int EXP_POS    = 0;
`endif

  pc_fetch_unit dut (
    .CLK(CLK), .Reset(Reset), .PCWre(PCWre), .PCSrc(PCSrc),
    .extendImme(extendImme), .jumpAddr(jumpAddr),
    .imemReady(imemReady), .imemData(imemData),
    .imemReq(imemReq), .imemAddr(imemAddr), .curPC(curPC), .nextPC(nextPC),
    .instr(instr), .instrValid(instrValid), .imme(imme), .fetchErr(fetchErr)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Accept the current instruction and wait (bounded) for the next one
  task automatic advance(input logic [1:0] src, input logic [31:0] ext, input logic [25:0] ja);
    int n;
    PCSrc = src; extendImme = ext; jumpAddr = ja; PCWre = 1'b1; imemReady = 1'b1;
    tick();
    PCWre = 1'b0;
    n = 0;
    while (!instrValid && n < 8) begin tick(); n++; end
    checks++;
    if (instrValid !== 1'b1) begin
      $display("FAIL advance_wait instrValid=%b required=1", instrValid); errors++;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; PCWre = 1'b0; PCSrc = 2'b00; extendImme = '0; jumpAddr = '0;
    imemReady = 1'b0; imemData = 32'hDEADBEEF;
    tick(); tick();
    checks++; if (curPC !== 32'h0) begin $display("FAIL reset_pc curPC=%h required=%h", curPC, 32'h0); errors++; end
    checks++; if (instr !== 32'h0) begin $display("FAIL reset_instr instr=%h required=%h", instr, 32'h0); errors++; end
    checks++; if (instrValid !== 1'b0) begin $display("FAIL reset_valid instrValid=%b required=0", instrValid); errors++; end
    checks++; if (imemReq !== 1'b0) begin $display("FAIL reset_req imemReq=%b required=0", imemReq); errors++; end
    checks++; if (fetchErr !== 1'b0) begin $display("FAIL reset_err fetchErr=%b required=0", fetchErr); errors++; end
  endtask

  task automatic test_first_fetch();
    imemReady = 1'b1; imemData = 32'h2001000A;
    Reset = 1'b0;
    tick();
    checks++; if (imemReq !== 1'b1) begin $display("FAIL first_req imemReq=%b required=1", imemReq); errors++; end
    checks++; if (instrValid !== 1'b0) begin $display("FAIL first_early instrValid=%b required=0", instrValid); errors++; end
    tick();
    checks++; if (instrValid !== 1'b1) begin $display("FAIL first_valid instrValid=%b required=1", instrValid); errors++; end
    checks++; if (curPC !== 32'h0) begin $display("FAIL first_pc curPC=%h required=%h", curPC, 32'h0); errors++; end
    checks++; if (imme !== 16'h000A) begin $display("FAIL first_imme imme=%h required=%h", imme, 16'h000A); errors++; end
    checks++; if (instr !== 32'h2001000A) begin $display("FAIL first_instr instr=%h required=%h", instr, 32'h2001000A); errors++; end
    checks++; if (imemAddr !== 32'h0) begin $display("FAIL first_addr imemAddr=%h required=%h", imemAddr, 32'h0); errors++; end
    checks++; if (nextPC !== 32'h4) begin $display("FAIL first_next nextPC=%h required=%h", nextPC, 32'h4); errors++; end
  endtask

  task automatic test_sequential();
    PCSrc = 2'b00; PCWre = 1'b1; imemReady = 1'b0; imemData = 32'h11111111;
    tick();
    PCWre = 1'b0;
    checks++; if (curPC !== 32'h4) begin $display("FAIL seq_pc curPC=%h required=%h", curPC, 32'h4); errors++; end
    checks++; if (instrValid !== 1'b0) begin $display("FAIL seq_valid instrValid=%b required=0", instrValid); errors++; end
    checks++; if (imemReq !== 1'b1) begin $display("FAIL seq_req imemReq=%b required=1", imemReq); errors++; end
    imemReady = 1'b1;
    tick();
    checks++; if (instr !== 32'h11111111) begin $display("FAIL seq_instr instr=%h required=%h", instr, 32'h11111111); errors++; end
    PCSrc = 2'b11; PCWre = 1'b1;
    checks++; if (nextPC !== 32'h8) begin $display("FAIL seq11_next nextPC=%h required=%h", nextPC, 32'h8); errors++; end
    tick();
    PCWre = 1'b0;
    checks++; if (curPC !== 32'h8) begin $display("FAIL seq11_pc curPC=%h required=%h", curPC, 32'h8); errors++; end
    tick();
    advance(2'b00, 32'h0, 26'h0);
    advance(2'b00, 32'h0, 26'h0);
    checks++; if (curPC !== 32'h10) begin $display("FAIL seq_walk curPC=%h required=%h", curPC, 32'h10); errors++; end
  endtask

  task automatic test_branch();
    PCSrc = 2'b01; extendImme = 32'hFFFFFFFE; PCWre = 1'b1; imemReady = 1'b1; imemData = 32'h8C22FFFC;
    #1;
    checks++; if (nextPC !== 32'hC) begin $display("FAIL br_next nextPC=%h required=%h", nextPC, 32'hC); errors++; end
    tick();
    PCWre = 1'b0;
    checks++; if (curPC !== 32'hC) begin $display("FAIL br_pc curPC=%h required=%h", curPC, 32'hC); errors++; end
    checks++; if (instrValid !== 1'b0) begin $display("FAIL br_valid instrValid=%b required=0", instrValid); errors++; end
    tick();
    checks++; if (instrValid !== 1'b1) begin $display("FAIL br_refetch instrValid=%b required=1", instrValid); errors++; end
  endtask

  task automatic test_hold();
    PCWre = 1'b0; PCSrc = 2'b10;
    for (int i = 0; i < 5; i++) begin
      imemData = (i % 2 == 0) ? 32'hA5A5A5A5 : 32'h5A5A5A5A;
      imemReady = (i % 2 == 0);
      tick();
      checks++;
      if (curPC !== 32'hC || instr !== 32'h8C22FFFC || instrValid !== 1'b1 || imme !== 16'hFFFC) begin
        $display("FAIL hold_%0d curPC=%h instr=%h instrValid=%b imme=%h required %h %h 1 %h",
                 i, curPC, instr, instrValid, imme, 32'hC, 32'h8C22FFFC, 16'hFFFC);
        errors++;
      end
    end
  endtask

  task automatic test_jump();
    advance(2'b01, 32'h0FFFFFFC, 26'h0);
    checks++; if (curPC !== 32'h40000000) begin $display("FAIL jmp_setup curPC=%h required=%h", curPC, 32'h40000000); errors++; end
    PCSrc = 2'b10; jumpAddr = 26'h0000100; PCWre = 1'b1;
    tick();
    PCWre = 1'b0;
    checks++; if (curPC !== 32'h40000400) begin $display("FAIL jmp_pc curPC=%h required=%h", curPC, 32'h40000400); errors++; end
    tick();
  endtask

  task automatic test_wrap();
    advance(2'b01, 32'h2FFFFEFE, 26'h0);
    checks++; if (curPC !== 32'hFFFFFFFC) begin $display("FAIL wrap_setup curPC=%h required=%h", curPC, 32'hFFFFFFFC); errors++; end
    PCSrc = 2'b10; jumpAddr = 26'h3FFFFFF;
    #1;
    checks++; if (nextPC !== 32'h0FFFFFFC) begin $display("FAIL wrap_jnext nextPC=%h required=%h", nextPC, 32'h0FFFFFFC); errors++; end
    PCSrc = 2'b00; PCWre = 1'b1; imemReady = 1'b0;
    tick();
    PCWre = 1'b0;
    checks++; if (curPC !== 32'h0) begin $display("FAIL wrap_pc curPC=%h required=%h", curPC, 32'h0); errors++; end
  endtask

  task automatic test_timeout();
    int pulses = 0;
    int pos = 0;
    int req_low = 0;
    imemReady = 1'b0; PCWre = 1'b1; PCSrc = 2'b01; extendImme = 32'h100;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (fetchErr === 1'b1) begin pulses++; pos = k; end
      if (imemReq !== 1'b1) req_low++;
    end
    PCWre = 1'b0;
    checks++; if (pulses !== EXP_PULSES) begin $display("FAIL to_pulses count=%0d required=%0d", pulses, EXP_PULSES); errors++; end
    checks++; if (pos !== EXP_POS) begin $display("FAIL to_pos cycle=%0d required=%0d", pos, EXP_POS); errors++; end
    checks++; if (req_low !== 0) begin $display("FAIL to_req low_cycles=%0d required=0", req_low); errors++; end
    checks++; if (curPC !== 32'h0) begin $display("FAIL to_pcwre_ignored curPC=%h required=%h", curPC, 32'h0); errors++; end
    imemReady = 1'b1; imemData = 32'h0800_0040;
    tick();
    checks++; if (instrValid !== 1'b1) begin $display("FAIL to_recover instrValid=%b required=1", instrValid); errors++; end
  endtask

  task automatic test_reset_mid_fetch();
    PCSrc = 2'b01; extendImme = 32'h3F; PCWre = 1'b1; imemReady = 1'b0;
    tick();
    PCWre = 1'b0;
    checks++; if (curPC !== 32'h100 || imemReq !== 1'b1) begin
      $display("FAIL mid_setup curPC=%h imemReq=%b required %h 1", curPC, imemReq, 32'h100); errors++;
    end
    #2;
    Reset = 1'b1;
    #1;
    checks++; if (curPC !== 32'h0) begin $display("FAIL mid_pc curPC=%h required=%h", curPC, 32'h0); errors++; end
    checks++; if (instrValid !== 1'b0) begin $display("FAIL mid_valid instrValid=%b required=0", instrValid); errors++; end
    checks++; if (imemReq !== 1'b0) begin $display("FAIL mid_req imemReq=%b required=0", imemReq); errors++; end
    imemReady = 1'b1; imemData = 32'hCAFEF00D;
    tick();
    Reset = 1'b0;
    tick();
    checks++; if (instrValid !== 1'b0 || imemReq !== 1'b1) begin
      $display("FAIL late_ready instrValid=%b imemReq=%b required 0 1", instrValid, imemReq); errors++;
    end
    tick();
    checks++; if (instrValid !== 1'b1 || instr !== 32'hCAFEF00D) begin
      $display("FAIL post_reset_fetch instrValid=%b instr=%h required 1 %h", instrValid, instr, 32'hCAFEF00D); errors++;
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_sequential();
    test_branch();
    test_hold();
    test_jump();
    test_wrap();
    test_timeout();
    test_reset_mid_fetch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, SHALL be the PC value loaded on reset.
REQ-002 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 PCWre  input  1  SHALL be the PC write enable; 0 stalls the PC.
REQ-005 PCSrc  input  2  SHALL select the next PC: 00 sequential, 01 branch, 10 jump, 11 sequential.
REQ-006 extendImme  input  32  SHALL be the sign-extended branch offset (word units) from the immediate extender.
REQ-007 jumpAddr  input  26  SHALL be the J-type target field.
REQ-008 imemReady  input  1  SHALL be the instruction memory data-valid strobe.
REQ-009 imemData  input  32  SHALL be the instruction word, sampled only when imemReady=1 in REQ.
REQ-010 imemReq  output  1  SHALL request a fetch at imemAddr.
REQ-011 imemAddr  output  32  SHALL equal curPC.
REQ-012 curPC  output  32  SHALL be the registered program counter.
REQ-013 nextPC  output  32  SHALL be the combinational next-PC value.
REQ-014 instr  output  32  SHALL be the registered instruction.
REQ-015 instrValid  output  1  SHALL mark instr as valid for the current curPC.
REQ-016 imme  output  16  SHALL equal instr[15:0], feeding the immediate extender.
REQ-017 fetchErr  output  1  SHALL pulse on a fetch timeout (see Configuration).

Function
REQ-018 FSM states: IDLE, REQ, VALID; encoding is free.
REQ-019 IDLE SHALL move to REQ on the next edge unconditionally; imemReq=0 in IDLE.
REQ-020 REQ SHALL drive imemReq=1; on imemReady=1: instr<=imemData, instrValid<=1, move to VALID; ready in the first REQ cycle is legal; minimum latency is 1 edge from entering REQ to instrValid=1.
REQ-021 VALID with PCWre=1 SHALL: curPC<=nextPC, instrValid<=0, move to REQ; with PCWre=0, hold all state.
REQ-022 imemReady outside REQ and PCWre outside VALID SHALL be ignored.
REQ-023 nextPC sequential = curPC+4; branch = curPC+4+(extendImme<<2); jump = {(curPC+4)[31:28], jumpAddr, 2'b00}.
REQ-024 All PC arithmetic SHALL be 32-bit and wrap modulo 2^32 (e.g. 32'hFFFFFFFC+4 = 0).
REQ-025 instr and imme SHALL remain stable while in VALID, regardless of imemData.

Reset
REQ-026 On Reset=1, asynchronously: state=IDLE, curPC=RESET_PC, instr=0, instrValid=0, imemReq=0, fetchErr=0, timeout counter=0.
REQ-027 Reset asserted mid-fetch SHALL abandon the fetch; a late imemReady after reset release SHALL be ignored unless the unit is in REQ.

Configuration
REQ-028 Macro FETCH_TIMEOUT_EN defined: a 4-bit counter SHALL count consecutive REQ cycles with imemReady=0 and clear on ready or on leaving REQ.
REQ-029 With FETCH_TIMEOUT_EN: on the 16th consecutive such cycle, fetchErr SHALL pulse high for exactly 1 cycle; the counter SHALL clear; the unit SHALL stay in REQ with imemReq=1.
REQ-030 Without FETCH_TIMEOUT_EN: no counter; fetchErr SHALL be constant 0; REQ waits indefinitely.

Verification
REQ-031 Reset release, imemReady=1 held, imemData=32'h2001000A -> curPC=0, instrValid=1 two edges after release, imme=16'h000A.
REQ-032 VALID, curPC=32'h00000010, PCSrc=01, extendImme=32'hFFFFFFFE, PCWre=1 -> curPC becomes 32'h0000000C.
REQ-033 VALID, curPC=32'h40000000, PCSrc=10, jumpAddr=26'h0000100 -> curPC becomes 32'h40000400.
REQ-034 VALID with PCWre=0 for 5 cycles while imemData toggles -> curPC, instr and instrValid are unchanged.
REQ-035 FETCH_TIMEOUT_EN defined, imemReady=0 for 20 REQ cycles -> exactly one fetchErr pulse on the 16th cycle; imemReq stays 1.
REQ-036 Reset asserted in REQ with curPC=32'h100 -> immediately curPC=RESET_PC, instrValid=0, imemReq=0.
